// File: rtl/mii_net_crc32_stream_if.sv
// Byte-lane ready/valid stream used on both sides of mii_net_crc32_stream.
// Lane k of data is bits [8k+7:8k]; lane 0 is the earliest byte on the wire.
interface mii_net_crc32_stream_if #(
  parameter int DATA_BYTES = 1
) ();
  logic [8*DATA_BYTES-1:0] data;
  logic [DATA_BYTES-1:0]   keep;
  logic                    valid;
  logic                    last;
  logic                    ready;

  modport master (output data, keep, valid, last, input ready);
  modport slave  (input data, keep, valid, last, output ready);
endinterface

// File: rtl/mii_net_crc32_stream.sv
// Streaming Ethernet FCS engine (reflected CRC-32, poly 0xEDB88320).
// Generate mode appends the 4-byte FCS after the last data beat; check mode
// forwards the frame untouched and pulses a good/bad status after it.
// Optional statistics counters are built when MII_CRC_STATS_EN is defined.
module mii_net_crc32_stream #(
  parameter int          DATA_BYTES  = 1,
  parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3
) (
  input  logic                         i_clk,
  input  logic                         i_nreset,
  input  logic                         i_check,
  mii_net_crc32_stream_if.slave        i_stream,
  mii_net_crc32_stream_if.master       o_stream,
  output logic [31:0]                  o_crc_reg,
  output logic                         o_status_valid,
  output logic                         o_fcs_ok
`ifdef MII_CRC_STATS_EN
  ,
  input  logic                         i_stats_clr,
  output logic [15:0]                  o_good_cnt,
  output logic [15:0]                  o_bad_cnt
`endif
);

  generate
    if ((DATA_BYTES != 1) && (DATA_BYTES != 2) && (DATA_BYTES != 4)) begin : g_bad_width
      $error("mii_net_crc32_stream: DATA_BYTES must be 1, 2 or 4");
    end
  endgenerate

  localparam int         FCS_BEATS = (4 + DATA_BYTES - 1) / DATA_BYTES;
  localparam logic [1:0] FCS_LAST  = 2'(FCS_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_FCS  = 2'd2
  } state_t;

  // Fold every kept lane, lane 0 first, each byte LSB-first.
  function automatic logic [31:0] crc_fold(
    input logic [31:0]               crc_in,
    input logic [8*DATA_BYTES-1:0]   data,
    input logic [DATA_BYTES-1:0]     keep
  );
    logic [31:0] c;
    c = crc_in;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (keep[k]) begin
        for (int b = 0; b < 8; b++) begin
          if (c[0] ^ data[8*k+b]) begin
            c = (c >> 1) ^ 32'hEDB8_8320;
          end else begin
            c = c >> 1;
          end
        end
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // FCS bytes for output beat 'beat': byte n of the FCS is ~crc[8n+7:8n].
  function automatic logic [8*DATA_BYTES-1:0] fcs_lanes(
    input logic [31:0] crc_in,
    input logic [1:0]  beat
  );
    logic [31:0]             f;
    logic [8*DATA_BYTES-1:0] d;
    int                      idx;
    f = ~crc_in;
    d = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      idx = int'(beat) * DATA_BYTES + k;
      if (idx < 4) begin
        d[8*k +: 8] = 8'(f >> (8 * idx));
      end else begin
        d[8*k +: 8] = 8'h00;
      end
    end
    return d;
  endfunction

  // Lane mask of an FCS beat: only lanes that carry one of the four FCS bytes.
  function automatic logic [DATA_BYTES-1:0] fcs_keep(input logic [1:0] beat);
    logic [DATA_BYTES-1:0] m;
    m = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if ((int'(beat) * DATA_BYTES + k) < 4) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

  state_t                  r_state;
  logic                    r_mode;
  logic [31:0]             r_crc;
  logic [1:0]              r_fcs_cnt;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [DATA_BYTES-1:0]   r_keep;
  logic                    r_valid;
  logic                    r_last;
  logic                    r_status_valid;
  logic                    r_fcs_ok;
  logic                    r_run;

  logic                    w_out_free;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_mode;
  logic [31:0]             w_crc_base;
  logic [31:0]             w_crc_next;

  // Handshake and next-CRC decode; the first beat of a frame folds from CRC_INIT.
  always_comb begin
    w_out_free = (!r_valid) || o_stream.ready;
    w_ready    = r_run && (r_state != S_FCS) && w_out_free;
    w_accept   = i_stream.valid && w_ready;
    if (r_state == S_IDLE) begin
      w_mode     = i_check;
      w_crc_base = CRC_INIT;
    end else begin
      w_mode     = r_mode;
      w_crc_base = r_crc;
    end
    w_crc_next = crc_fold(w_crc_base, i_stream.data, i_stream.keep);
  end

  // Frame FSM, CRC register, output stage and status pulse.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state        <= S_IDLE;
      r_mode         <= 1'b0;
      r_crc          <= CRC_INIT;
      r_fcs_cnt      <= 2'd0;
      r_data         <= '0;
      r_keep         <= '0;
      r_valid        <= 1'b0;
      r_last         <= 1'b0;
      r_status_valid <= 1'b0;
      r_fcs_ok       <= 1'b0;
      r_run          <= 1'b0;
    end else begin
      r_run          <= 1'b1;
      r_status_valid <= 1'b0;
      // Output register empties when downstream takes it; a load below overrides.
      if (w_out_free) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE, S_DATA: begin
          if (w_accept) begin
            r_data  <= i_stream.data;
            r_keep  <= i_stream.keep;
            r_valid <= 1'b1;
            r_crc   <= w_crc_next;
            r_mode  <= w_mode;
            if (i_stream.last) begin
              if (w_mode) begin
                // Check mode: close the frame and report on the next cycle.
                r_last         <= 1'b1;
                r_status_valid <= 1'b1;
                r_fcs_ok       <= (w_crc_next == CRC_RESIDUE);
                r_state        <= S_IDLE;
              end else begin
                // Generate mode: the FCS beats carry the end of frame.
                r_last    <= 1'b0;
                r_fcs_cnt <= 2'd0;
                r_state   <= S_FCS;
              end
            end else begin
              r_last  <= 1'b0;
              r_state <= S_DATA;
            end
          end
        end
        S_FCS: begin
          if (w_out_free) begin
            r_data  <= fcs_lanes(r_crc, r_fcs_cnt);
            r_keep  <= fcs_keep(r_fcs_cnt);
            r_valid <= 1'b1;
            if (r_fcs_cnt == FCS_LAST) begin
              r_last  <= 1'b1;
              r_crc   <= CRC_INIT;
              r_state <= S_IDLE;
            end else begin
              r_last    <= 1'b0;
              r_fcs_cnt <= r_fcs_cnt + 2'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_crc   <= CRC_INIT;
        end
      endcase
    end
  end

  assign i_stream.ready  = w_ready;
  assign o_stream.data   = r_data;
  assign o_stream.keep   = r_keep;
  assign o_stream.valid  = r_valid;
  assign o_stream.last   = r_last;
  assign o_crc_reg       = r_crc;
  assign o_status_valid  = r_status_valid;
  assign o_fcs_ok        = r_fcs_ok;

`ifdef MII_CRC_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_bad_cnt;

  // Saturating good/bad frame counters; clear beats a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_good_cnt <= 16'h0000;
      r_bad_cnt  <= 16'h0000;
    end else if (i_stats_clr) begin
      r_good_cnt <= 16'h0000;
      r_bad_cnt  <= 16'h0000;
    end else if (r_status_valid) begin
      if (r_fcs_ok) begin
        if (r_good_cnt != 16'hFFFF) begin
          r_good_cnt <= r_good_cnt + 16'd1;
        end
      end else begin
        if (r_bad_cnt != 16'hFFFF) begin
          r_bad_cnt <= r_bad_cnt + 16'd1;
        end
      end
    end
  end

  assign o_good_cnt = r_good_cnt;
  assign o_bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_mii_net_crc32_stream.sv
// Self-checking bench for mii_net_crc32_stream: one instance per lane width
// (1, 2, 4) sharing a driver; 'sel' picks the instance under test.
module tb_mii_net_crc32_stream;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] drv_data = 32'h0;
  logic [3:0]  drv_keep = 4'h0;
  logic        drv_valid = 1'b0;
  logic        drv_last = 1'b0;
  logic        drv_check = 1'b0;
  logic        ds_ready = 1'b1;
  logic        stats_clr = 1'b0;
  int          sel = 0;

  always #5 clk = ~clk;

  mii_net_crc32_stream_if #(.DATA_BYTES(1)) in1 ();
  mii_net_crc32_stream_if #(.DATA_BYTES(1)) out1 ();
  mii_net_crc32_stream_if #(.DATA_BYTES(2)) in2 ();
  mii_net_crc32_stream_if #(.DATA_BYTES(2)) out2 ();
  mii_net_crc32_stream_if #(.DATA_BYTES(4)) in4 ();
  mii_net_crc32_stream_if #(.DATA_BYTES(4)) out4 ();

  assign in1.data  = drv_data[7:0];
  assign in1.keep  = drv_keep[0:0];
  assign in1.valid = drv_valid && (sel == 0);
  assign in1.last  = drv_last;
  assign out1.ready = (sel == 0) ? ds_ready : 1'b1;
  assign in2.data  = drv_data[15:0];
  assign in2.keep  = drv_keep[1:0];
  assign in2.valid = drv_valid && (sel == 1);
  assign in2.last  = drv_last;
  assign out2.ready = (sel == 1) ? ds_ready : 1'b1;
  assign in4.data  = drv_data;
  assign in4.keep  = drv_keep;
  assign in4.valid = drv_valid && (sel == 2);
  assign in4.last  = drv_last;
  assign out4.ready = (sel == 2) ? ds_ready : 1'b1;

  logic [31:0] crc1, crc2, crc4;
  logic        sv1, sv2, sv4, ok1, ok2, ok4;
`ifdef MII_CRC_STATS_EN
  logic [15:0] g1, g2, g4, b1, b2, b4;
`endif

  mii_net_crc32_stream #(.DATA_BYTES(1)) u_db1 (
    .i_clk(clk), .i_nreset(nreset), .i_check(drv_check),
    .i_stream(in1), .o_stream(out1),
    .o_crc_reg(crc1), .o_status_valid(sv1), .o_fcs_ok(ok1)
`ifdef MII_CRC_STATS_EN
    , .i_stats_clr(stats_clr), .o_good_cnt(g1), .o_bad_cnt(b1)
`endif
  );
  mii_net_crc32_stream #(.DATA_BYTES(2)) u_db2 (
    .i_clk(clk), .i_nreset(nreset), .i_check(drv_check),
    .i_stream(in2), .o_stream(out2),
    .o_crc_reg(crc2), .o_status_valid(sv2), .o_fcs_ok(ok2)
`ifdef MII_CRC_STATS_EN
    , .i_stats_clr(stats_clr), .o_good_cnt(g2), .o_bad_cnt(b2)
`endif
  );
  mii_net_crc32_stream #(.DATA_BYTES(4)) u_db4 (
    .i_clk(clk), .i_nreset(nreset), .i_check(drv_check),
    .i_stream(in4), .o_stream(out4),
    .o_crc_reg(crc4), .o_status_valid(sv4), .o_fcs_ok(ok4)
`ifdef MII_CRC_STATS_EN
    , .i_stats_clr(stats_clr), .o_good_cnt(g4), .o_bad_cnt(b4)
`endif
  );

  logic [31:0] obs_data, obs_crc;
  logic [3:0]  obs_keep;
  logic        obs_valid, obs_last, obs_ready, obs_sv, obs_ok;

  // Route the selected instance onto common observation signals.
  always_comb begin
    case (sel)
      0: begin
        obs_data = {24'h0, out1.data}; obs_keep = {3'b0, out1.keep};
        obs_valid = out1.valid; obs_last = out1.last; obs_ready = in1.ready;
        obs_crc = crc1; obs_sv = sv1; obs_ok = ok1;
      end
      1: begin
        obs_data = {16'h0, out2.data}; obs_keep = {2'b0, out2.keep};
        obs_valid = out2.valid; obs_last = out2.last; obs_ready = in2.ready;
        obs_crc = crc2; obs_sv = sv2; obs_ok = ok2;
      end
      default: begin
        obs_data = out4.data; obs_keep = out4.keep;
        obs_valid = out4.valid; obs_last = out4.last; obs_ready = in4.ready;
        obs_crc = crc4; obs_sv = sv4; obs_ok = ok4;
      end
    endcase
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] crc_tbl[256];
  beat_t       beats[$];
  logic [7:0]  got_q[$];
  logic        st_q[$];
  logic [31:0] st_crc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: table-driven reflected CRC-32, register value (not complemented).
  function automatic logic [31:0] model_reg(bytes_t q);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) c = (c >> 8) ^ crc_tbl[c[7:0] ^ q[i]];
    return c;
  endfunction

  function automatic bytes_t with_fcs(bytes_t q);
    bytes_t      r;
    logic [31:0] f;
    r = q;
    f = ~model_reg(q);
    for (int n = 0; n < 4; n++) r.push_back(8'(f >> (8 * n)));
    return r;
  endfunction

  function automatic bytes_t rand_bytes(int n);
    bytes_t r;
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    return r;
  endfunction

  function automatic int db_of(int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
  endfunction

  // Split a frame into beats of the current width; optionally insert an
  // all-zero-keep beat before beat 'zero_at' or as the closing beat.
  task automatic add_frame(input bytes_t fb, input int zero_at, input bit zero_last);
    beat_t b;
    int    i, bi, db;
    db = db_of(sel); i = 0; bi = 0;
    while (i < fb.size()) begin
      if (bi == zero_at) begin
        b.d = $urandom; b.k = 4'h0; b.l = 1'b0; beats.push_back(b);
      end
      b.d = 32'h0; b.k = 4'h0;
      for (int ln = 0; ln < db && i < fb.size(); ln++) begin
        b.d[8*ln +: 8] = fb[i]; b.k[ln] = 1'b1; i++;
      end
      b.l = (i == fb.size()) && !zero_last;
      beats.push_back(b);
      bi++;
    end
    if (zero_last) begin
      b.d = $urandom; b.k = 4'h0; b.l = 1'b1; beats.push_back(b);
    end
  endtask

  // Drive queued beats and collect output bytes and status pulses.
  task automatic drive(input bit chk_mode, input int vpct, input int rpct,
                       input int n_last, input bit abort_fcs);
    int          cyc, last_acc, outs, db;
    bit          in_frame, pend, prev_stall;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    db = db_of(sel); cyc = 0; last_acc = -10; outs = 0;
    in_frame = 1'b0; pend = 1'b0; prev_stall = 1'b0; pd = 32'h0; pk = 4'h0; pl = 1'b0;
    while ((beats.size() > 0 || outs < n_last) && cyc < 4000) begin
      if (beats.size() > 0 && $urandom_range(99) < vpct) begin
        drv_valid = 1'b1; drv_data = beats[0].d; drv_keep = beats[0].k; drv_last = beats[0].l;
      end else begin
        drv_valid = 1'b0; drv_data = $urandom; drv_keep = 4'($urandom); drv_last = 1'($urandom);
      end
      ds_ready  = ($urandom_range(99) < rpct);
      drv_check = in_frame ? 1'($urandom) : chk_mode;
      #2;
      if (obs_sv) begin
        st_q.push_back(obs_ok);
        st_crc_q.push_back(obs_crc);
        chk("status_timing", 32'(cyc), 32'(last_acc + 1));
      end
      if (prev_stall) begin
        chk("hold_valid", {31'h0, obs_valid}, 32'h1);
        chk("hold_data", obs_data, pd);
        chk("hold_keep", {28'h0, obs_keep}, {28'h0, pk});
        chk("hold_last", {31'h0, obs_last}, {31'h0, pl});
      end
      if (pend && !(obs_valid && obs_last)) chk("ready_in_fcs", {31'h0, obs_ready}, 32'h0);
      if (obs_valid && ds_ready) begin
        for (int k = 0; k < db; k++) if (obs_keep[k]) got_q.push_back(obs_data[8*k +: 8]);
        if (obs_last) begin outs++; pend = 1'b0; end
      end
      prev_stall = obs_valid && !ds_ready;
      pd = obs_data; pk = obs_keep; pl = obs_last;
      if (drv_valid && obs_ready) begin
        if (beats[0].l) begin
          last_acc = cyc; in_frame = 1'b0;
          if (!chk_mode) pend = 1'b1;
        end else begin
          in_frame = 1'b1;
        end
        void'(beats.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_fcs && pend) break;
    end
    drv_valid = 1'b0; ds_ready = 1'b1;
    if (!abort_fcs) chk("within_budget", {31'h0, cyc < 4000}, 32'h1);
  endtask

  task automatic cmp_bytes(input string tag, input bytes_t exp);
    int n;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp.size()));
    n = (got_q.size() < exp.size()) ? got_q.size() : exp.size();
    for (int i = 0; i < n; i++) chk(tag, {24'h0, got_q[i]}, {24'h0, exp[i]});
  endtask

  task automatic clear_obs();
    got_q.delete(); st_q.delete(); st_crc_q.delete();
  endtask

  initial begin
    bytes_t      s9, e, fa, fb2;
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[n] = c;
    end
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // Reset state.
    #12;
    chk("rst_ready", {31'h0, obs_ready}, 32'h0);
    chk("rst_valid", {31'h0, obs_valid}, 32'h0);
    chk("rst_crc", obs_crc, 32'hFFFF_FFFF);
    chk("rst_status", {30'h0, obs_sv, obs_ok}, 32'h0);
    #5 nreset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'h0, obs_ready}, 32'h1);

    // DB=1 generate "123456789": FCS 26 39 F4 CB after the data.
    sel = 0; clear_obs();
    add_frame(s9, -1, 1'b0);
    drive(1'b0, 100, 100, 1, 1'b0);
    e = s9; e.push_back(8'h26); e.push_back(8'h39); e.push_back(8'hF4); e.push_back(8'hCB);
    cmp_bytes("gen1_123456789", e);
    chk("gen1_no_status", 32'(st_q.size()), 32'h0);

    // DB=4 check of the good frame.
    sel = 2; clear_obs();
    add_frame(e, -1, 1'b0);
    drive(1'b1, 100, 100, 1, 1'b0);
    cmp_bytes("chk4_pass", e);
    chk("chk4_pulses", 32'(st_q.size()), 32'h1);
    if (st_q.size() > 0) begin
      chk("chk4_ok", {31'h0, st_q[0]}, 32'h1);
      chk("chk4_residue", st_crc_q[0], 32'hDEBB_20E3);
    end
`ifdef MII_CRC_STATS_EN
    @(posedge clk); #1;
    chk("stats_good1", {16'h0, g4}, 32'h1);
    stats_clr = 1'b1; @(posedge clk); #1; stats_clr = 1'b0;
    chk("stats_clr", {g4, b4}, 32'h0);
`endif

    // Same frame with a corrupted FCS byte.
    clear_obs();
    e[12] = 8'hCA;
    add_frame(e, -1, 1'b0);
    drive(1'b1, 100, 100, 1, 1'b0);
    chk("bad4_pulses", 32'(st_q.size()), 32'h1);
    if (st_q.size() > 0) chk("bad4_ok", {31'h0, st_q[0]}, 32'h0);
`ifdef MII_CRC_STATS_EN
    @(posedge clk); #1;
    chk("stats_bad", {16'h0, b4}, 32'h1);
    chk("stats_good0", {16'h0, g4}, 32'h0);
`endif

    // DB=2 generate, 60 random bytes, random gaps and stalls, empty beat inside.
    sel = 1; clear_obs();
    fa = rand_bytes(60);
    add_frame(fa, 7, 1'b0);
    drive(1'b0, 60, 50, 1, 1'b0);
    cmp_bytes("gen2_random", with_fcs(fa));

    // DB=2 check, frame closed by an all-zero-keep last beat.
    clear_obs();
    fa = with_fcs(rand_bytes(31));
    add_frame(fa, -1, 1'b1);
    drive(1'b1, 70, 60, 1, 1'b0);
    cmp_bytes("chk2_zero_last", fa);
    chk("chk2_pulses", 32'(st_q.size()), 32'h1);
    if (st_q.size() > 0) chk("chk2_ok", {31'h0, st_q[0]}, 32'h1);

    // DB=4 generate with a partial last beat under stalls.
    sel = 2; clear_obs();
    fa = rand_bytes(23);
    add_frame(fa, -1, 1'b0);
    drive(1'b0, 80, 40, 1, 1'b0);
    cmp_bytes("gen4_partial", with_fcs(fa));

    // DB=1: reset while in FCS, then a clean frame.
    sel = 0; clear_obs();
    add_frame(s9, -1, 1'b0);
    drive(1'b0, 100, 0, 1, 1'b1);
    #2 nreset = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, obs_valid}, 32'h0);
    chk("midrst_last", {31'h0, obs_last}, 32'h0);
    chk("midrst_data", obs_data, 32'h0);
    chk("midrst_keep", {28'h0, obs_keep}, 32'h0);
    chk("midrst_ready", {31'h0, obs_ready}, 32'h0);
    chk("midrst_status", {30'h0, obs_sv, obs_ok}, 32'h0);
    #3 nreset = 1'b1;
    @(posedge clk); #1;
    clear_obs(); beats.delete();
    add_frame(s9, -1, 1'b0);
    drive(1'b0, 100, 100, 1, 1'b0);
    e = s9; e.push_back(8'h26); e.push_back(8'h39); e.push_back(8'hF4); e.push_back(8'hCB);
    cmp_bytes("after_rst_gen1", e);

    // DB=4 back-to-back check frames, good then bad, no gap.
    sel = 2; clear_obs();
    fa = with_fcs(rand_bytes(20));
    fb2 = with_fcs(rand_bytes(15));
    fb2[fb2.size() - 1] = fb2[fb2.size() - 1] ^ 8'h01;
    add_frame(fa, -1, 1'b0);
    add_frame(fb2, -1, 1'b0);
    drive(1'b1, 100, 100, 2, 1'b0);
    chk("b2b_pulses", 32'(st_q.size()), 32'h2);
    if (st_q.size() > 1) begin
      chk("b2b_ok_a", {31'h0, st_q[0]}, 32'h1);
      chk("b2b_ok_b", {31'h0, st_q[1]}, 32'h0);
      chk("b2b_crc_b", st_crc_q[1], model_reg(fb2));
    end
    e = fa;
    foreach (fb2[i]) e.push_back(fb2[i]);
    cmp_bytes("b2b_pass", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mii_net_crc32_stream.md
Name: mii_net_crc32_stream

Overview:
- Parametrised successor to the byte-wide mii_net_crc32 engine.
- Processes an Ethernet frame on a ready/valid byte-lane stream of DATA_BYTES lanes, with byte enables on every beat.
- Generate mode: appends the 4-byte FCS after the last data beat (TX path).
- Check mode: passes the frame through unchanged and reports FCS good/bad on the last beat (RX path).
- Sits between the MAC framer and the MII nibble/byte serialiser.

Parameters:
- DATA_BYTES, 1: lanes per beat. Legal values are 1, 2 and 4; any other value triggers an elaboration $error.
- CRC_INIT, 32'hFFFF_FFFF: register preset at frame start.
- CRC_RESIDUE, 32'hDEBB_20E3: register value after data plus a correct FCS, used in check mode.

Ports:
- i_clk, in, 1: system clock.
- i_nreset, in, 1: asynchronous active-low reset.
- i_check, in, 1: mode select, sampled on the first accepted beat of a frame. 1 = check, 0 = generate.
- i_data, in, 8*DATA_BYTES: lane k is bits [8k+7:8k]. Lane 0 is the earliest byte.
- i_keep, in, DATA_BYTES: lane valid mask. Must be contiguous from lane 0; a non-contiguous mask is undefined.
- i_valid, in, 1: input beat valid.
- i_last, in, 1: final data beat of the frame.
- o_ready, out, 1: block accepts the input beat.
- o_data, out, 8*DATA_BYTES: output lanes.
- o_keep, out, DATA_BYTES: output lane mask.
- o_valid, out, 1: output beat valid.
- o_last, out, 1: final output beat of the frame.
- i_ready, in, 1: downstream accepts the output beat.
- o_crc_reg, out, 32: live CRC register, not complemented.
- o_status_valid, out, 1: one-cycle pulse when a check-mode frame completes.
- o_fcs_ok, out, 1: check result. Meaningful only while o_status_valid is high.

Behaviour:
- CRC definition:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB-first within each byte.
  - Lanes with keep=1 are folded in lane order 0..DATA_BYTES-1 within one cycle; lanes with keep=0 leave the register unchanged.
  - FCS byte n = ~crc[8n+7:8n], n = 0..3, transmitted n=0 first.
- Reset (async, i_nreset low): state=IDLE, crc=CRC_INIT, o_valid=0, o_last=0, o_keep=0, o_data=0, o_status_valid=0, o_fcs_ok=0, o_ready=0.
- Output register:
  - Single stage, one-cycle latency from input accept to o_valid.
  - o_data, o_keep, o_last hold stable while o_valid && !i_ready.
  - o_ready = (state != FCS) && (!o_valid || i_ready). Registered input path, no combinational i_ready→o_data path.
- FSM:
  - IDLE: crc=CRC_INIT. First accepted beat latches i_check into mode, folds the data, goes to DATA. If that beat also has i_last, the DATA exit rules apply on the same cycle.
  - DATA: each accepted beat folds and forwards.
    - On an accepted beat with i_last in generate mode: forwarded beat has o_last=0; FCS counter loads 0; go to FCS.
    - On an accepted beat with i_last in check mode: forwarded beat has o_last=1. Next cycle pulses o_status_valid, with o_fcs_ok = (crc after that beat == CRC_RESIDUE). Go to IDLE.
  - FCS (generate only): emits ceil(4/DATA_BYTES) beats.
    - Beat j carries FCS bytes j*DATA_BYTES upward in lanes from 0.
    - o_keep marks the bytes present; for DATA_BYTES=1/2/4 every FCS beat is full.
    - The last FCS beat has o_last=1.
    - Advances only when the output register is free (!o_valid || i_ready). FCS bytes come from the crc frozen at the end of data.
    - After the last FCS beat is loaded, go to IDLE with crc=CRC_INIT.
- Boundary conditions:
  - All-zero i_keep beat: accepted, crc unchanged, forwarded with keep=0. If it carries i_last, it still closes the frame.
  - Back-to-back frames: a new frame may be accepted the cycle after the FSM enters IDLE. No bubble is required in check mode.
  - i_check changes mid-frame: ignored.
  - Reset mid-frame: the frame is dropped, with no status pulse and no partial FCS.
  - Downstream stalls: never lose or duplicate a beat; crc folds only on input handshake.

Optional Feature:
- Macro MII_CRC_STATS_EN.
- When defined:
  - Adds outputs o_good_cnt[15:0] and o_bad_cnt[15:0], plus input i_stats_clr.
  - Counters increment on o_status_valid with o_fcs_ok=1 and 0 respectively, saturating at 16'hFFFF.
  - Reset to 0 on i_nreset or synchronous i_stats_clr; clear wins over a simultaneous increment.
- When undefined: ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- DATA_BYTES=1, generate, "123456789" (31..39) → nine data beats, then FCS beats 26,39,F4,CB; last has o_last=1.
- DATA_BYTES=4, check, "123456789" plus 26 39 F4 CB (13 bytes, last beat keep=4'b0001) → o_status_valid one cycle after last, o_fcs_ok=1, o_crc_reg=DEBB20E3.
- Same frame with FCS byte CB→CA → o_fcs_ok=0. With MII_CRC_STATS_EN: bad_cnt=1, good_cnt=0.
- DATA_BYTES=2, generate, random i_ready at 50% and random i_valid gaps on a 60-byte frame → output byte stream equals input plus correct FCS; no drops or duplicates; o_ready=0 during FCS.
- Assert i_nreset low during the FCS state of a frame → all outputs zero immediately; the next frame "123456789" yields FCS CBF43926 uncorrupted.
- Two back-to-back check-mode frames with no gap, DATA_BYTES=4 → two status pulses, each result correct.
